// File: rtl/fifo_test_ctrl.sv
// fifo_test_ctrl: write/read sequencer that exercises a FIFO.
// Each round fills the FIFO with a rolling pattern, drains it, and checks
// every word read back. Pass and error statistics accumulate across rounds.
module fifo_test_ctrl #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_rd_en,
  output logic              busy,
  output logic              round_done,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       err_cnt,
  output logic              err_flag
);

  // Word counters carry one extra bit so the value DEPTH itself fits.
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C    = CW'(DEPTH - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_WAIT,
    S_WRITE,
    S_RD_WAIT,
    S_READ,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]     chk_cnt_q, chk_cnt_d;
  logic [15:0]       round_q, round_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rd_vld_q, rd_vld_d;
  logic              round_bad_q, round_bad_d;
  logic              round_done_q, round_done_d;
  logic [15:0]       pass_cnt_q, pass_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              err_flag_q, err_flag_d;

  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] exp_word;

  // Saturating 16-bit increment used by both statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end
    return v + 16'd1;
  endfunction

  // Enables are decoded from registered state so they drop the moment a flag asserts.
  assign wr_en    = (state_q == S_WRITE) && !fifo_full  && (wr_cnt_q < DEPTH_C);
  assign rd_en    = (state_q == S_READ)  && !fifo_empty && (rd_cnt_q < DEPTH_C);
  assign exp_word = DATA_W'(chk_cnt_q) + DATA_W'(round_q);

  assign fifo_wr_en = wr_en;
  assign fifo_rd_en = rd_en;
  assign fifo_din   = din_q;
  assign busy       = (state_q != S_IDLE);
  assign round_done = round_done_q;
  assign pass_cnt   = pass_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_flag   = err_flag_q;

  // Next-state, counter and statistics logic.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    chk_cnt_d    = chk_cnt_q;
    round_d      = round_q;
    din_d        = din_q;
    rd_vld_d     = rd_en;
    round_bad_d  = round_bad_q;
    round_done_d = 1'b0;
    pass_cnt_d   = pass_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_flag_d   = err_flag_q;

    // Check stage: read data arrives one cycle after the read enable.
    if (rd_vld_q) begin
      chk_cnt_d = chk_cnt_q + CW'(1);
      if (fifo_dout != exp_word) begin
        err_cnt_d   = sat_inc16(err_cnt_q);
        err_flag_d  = 1'b1;
        round_bad_d = 1'b1;
      end
    end

    // fifo_din always holds the word for the current wr_cnt, so it advances with each accepted write.
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
      din_d    = DATA_W'(wr_cnt_q) + DATA_W'(round_q) + DATA_W'(1);
    end

    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (start) begin
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_WRITE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WRITE: begin
        if (wr_en && (wr_cnt_q == LAST_C)) begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_READ;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_READ: begin
        if (rd_en && (rd_cnt_q == LAST_C)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The round closes on the same edge as the final check, so its result is included.
        if (chk_cnt_d == DEPTH_C) begin
          round_done_d = 1'b1;
          if (!round_bad_d) begin
            pass_cnt_d = sat_inc16(pass_cnt_q);
          end
          round_d     = round_q + 16'd1;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
          chk_cnt_d   = '0;
          round_bad_d = 1'b0;
          din_d       = DATA_W'(round_q + 16'd1);
          state_d     = start ? S_WR_WAIT : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers; reset returns everything to an idle, cleared block.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      chk_cnt_q    <= '0;
      round_q      <= '0;
      din_q        <= '0;
      rd_vld_q     <= 1'b0;
      round_bad_q  <= 1'b0;
      round_done_q <= 1'b0;
      pass_cnt_q   <= '0;
      err_cnt_q    <= '0;
      err_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      chk_cnt_q    <= chk_cnt_d;
      round_q      <= round_d;
      din_q        <= din_d;
      rd_vld_q     <= rd_vld_d;
      round_bad_q  <= round_bad_d;
      round_done_q <= round_done_d;
      pass_cnt_q   <= pass_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_flag_q   <= err_flag_d;
    end
  end

endmodule

// File: tb/tb_fifo_test_ctrl.sv
// Testbench for fifo_test_ctrl: behavioural FIFO with one-cycle read latency,
// write-data and round-result scoreboards, directed and randomized scenarios.
module tb_fifo_test_ctrl;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int WC  = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start   = 1'b0;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic          fifo_rd_en;
  logic          busy;
  logic          round_done;
  logic [15:0]   pass_cnt;
  logic [15:0]   err_cnt;
  logic          err_flag;

  typedef struct {
    int pass;
    int err;
    bit flag;
  } done_t;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_wr[$];
  done_t         exp_done[$];
  done_t         e;
  int            wr_total, rd_total, force_cnt, rnd_corr, tot_err, tot_pass;
  int            done_seen = 0;
  int            corrupt_idx = -1;
  logic [7:0]    corrupt_mask = 8'h01;
  bit            stall_mode, rand_stall, rand_corrupt;
  bit            set_force;
  logic [DW-1:0] w;
  logic [7:0]    m;
  int            k;

  fifo_test_ctrl #(.DATA_W(DW), .DEPTH(DEP), .WAIT_CYC(WC)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_rd_en (fifo_rd_en),
    .busy       (busy),
    .round_done (round_done),
    .pass_cnt   (pass_cnt),
    .err_cnt    (err_cnt),
    .err_flag   (err_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural FIFO: queue storage, registered flags, one-cycle read latency,
  // optional forced stalls and read-data corruption. It also derives the
  // expected statistics each time a round's last word leaves the FIFO.
  initial begin
    forever begin
      @(posedge sys_clk or posedge sys_rst);
      if (sys_rst) begin
        fq.delete();
        exp_done.delete();
        wr_total = 0; rd_total = 0; force_cnt = 0;
        rnd_corr = 0; tot_err = 0; tot_pass = 0;
        fifo_full  <= 1'b0;
        fifo_empty <= 1'b1;
        fifo_dout  <= '0;
      end else begin
        set_force = 1'b0;
        if (fifo_rd_en && !fifo_empty && fq.size() > 0) begin
          w = fq.pop_front();
          m = '0;
          if (rd_total == corrupt_idx) m = corrupt_mask;
          else if (rand_corrupt && $urandom_range(0, 11) == 0) m = 8'($urandom_range(1, 255));
          if (m != 8'h00) rnd_corr++;
          fifo_dout <= w ^ m;
          rd_total++;
          if (rd_total % DEP == 0) begin
            tot_err += rnd_corr;
            if (rnd_corr == 0) tot_pass++;
            exp_done.push_back('{tot_pass, tot_err, (tot_err != 0)});
            rnd_corr = 0;
          end
        end
        if (fifo_wr_en && !fifo_full) begin
          fq.push_back(fifo_din);
          wr_total++;
          if (stall_mode && wr_total == 6) begin
            force_cnt = 5;
            set_force = 1'b1;
          end
        end
        if (!set_force && force_cnt > 0) force_cnt--;
        fifo_full  <= (fq.size() >= DEP) || (force_cnt > 0) ||
                      (rand_stall && $urandom_range(0, 3) == 0);
        fifo_empty <= (fq.size() == 0) || (rand_stall && $urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: compares every write against the expected pattern and every
  // round_done pulse against the expected statistics.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        done_seen = 0;
      end else begin
        if (fifo_wr_en) begin
          chk("wr_while_full", 32'(fifo_full), 32'd0);
          chk("write_expected", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) chk("fifo_din", 32'(fifo_din), 32'(exp_wr.pop_front()));
        end
        if (fifo_rd_en) chk("rd_while_empty", 32'(fifo_empty), 32'd0);
        if (round_done) begin
          done_seen++;
          chk("done_expected", 32'(exp_done.size() > 0), 32'd1);
          if (exp_done.size() > 0) begin
            e = exp_done.pop_front();
            chk("round_pass_cnt", 32'(pass_cnt), 32'(e.pass));
            chk("round_err_cnt", 32'(err_cnt), 32'(e.err));
            chk("round_err_flag", 32'(err_flag), 32'(e.flag));
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    start = 1'b0;
    @(negedge sys_clk);
    sys_rst      = 1'b1;
    corrupt_idx  = -1;
    stall_mode   = 1'b0;
    rand_stall   = 1'b0;
    rand_corrupt = 1'b0;
    exp_wr.delete();
    cycles(3);
    sys_rst = 1'b0;
    cycles(2);
  endtask

  task automatic push_round(input int r);
    for (int i = 0; i < DEP; i++) exp_wr.push_back(8'(i + r));
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    if (done_seen < target) chk("round_done_timeout", 32'(done_seen), 32'(target));
  endtask

  // Runs n rounds from a freshly reset block; start drops during the last round.
  task automatic run_rounds(input int n);
    for (int r = 0; r < n; r++) push_round(r);
    start = 1'b1;
    if (n > 1) wait_done(n - 1);
    else wait_busy();
    start = 1'b0;
    wait_done(n);
    cycles(20);
    chk("idle_after_rounds", 32'(busy), 32'd0);
    chk("done_pulses", 32'(done_seen), 32'(n));
    chk("writes_drained", 32'(exp_wr.size()), 32'd0);
    chk("results_drained", 32'(exp_done.size()), 32'd0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    chk({tag, "_din"}, 32'(fifo_din), 32'd0);
    chk({tag, "_round_done"}, 32'(round_done), 32'd0);
    chk({tag, "_pass_cnt"}, 32'(pass_cnt), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_err_flag"}, 32'(err_flag), 32'd0);
  endtask

  initial begin
    // Reset state, then release with start low.
    cycles(3);
    chk_cleared("reset");
    sys_rst = 1'b0;
    cycles(10);
    chk("idle_no_start_busy", 32'(busy), 32'd0);
    chk("idle_no_start_wr", 32'(fifo_wr_en), 32'd0);

    // Nominal round with write-start latency.
    do_reset();
    push_round(0);
    start = 1'b1;
    wait_busy();
    start = 1'b0;
    k = 0;
    while (!fifo_wr_en && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    chk("first_write_delay", 32'(k), 32'(WC));
    wait_done(1);
    cycles(20);
    chk("nominal_pass_cnt", 32'(pass_cnt), 32'd1);
    chk("nominal_err_cnt", 32'(err_cnt), 32'd0);
    chk("nominal_err_flag", 32'(err_flag), 32'd0);
    chk("nominal_busy", 32'(busy), 32'd0);
    chk("nominal_done_pulses", 32'(done_seen), 32'd1);

    // Full stall after the 6th write.
    do_reset();
    stall_mode = 1'b1;
    run_rounds(1);
    chk("stall_pass_cnt", 32'(pass_cnt), 32'd1);

    // Corrupted read word 7 of round 0; round 1 clean.
    do_reset();
    corrupt_idx  = 7;
    corrupt_mask = 8'h01;
    run_rounds(2);
    chk("corrupt_pass_cnt", 32'(pass_cnt), 32'd1);
    chk("corrupt_err_cnt", 32'(err_cnt), 32'd1);
    chk("corrupt_err_flag", 32'(err_flag), 32'd1);

    // Asynchronous reset during READ after 5 reads.
    do_reset();
    push_round(0);
    start = 1'b1;
    wait_busy();
    start = 1'b0;
    k = 0;
    while (rd_total < 5 && k < 500) begin
      @(negedge sys_clk);
      k++;
    end
    chk("reached_five_reads", 32'(rd_total >= 5), 32'd1);
    #1 sys_rst = 1'b1;
    #1 chk_cleared("midread_reset");
    exp_wr.delete();
    cycles(2);
    sys_rst = 1'b0;
    cycles(2);

    // Restart from zero, then stop during round 2's write phase.
    for (int r = 0; r < 3; r++) push_round(r);
    start = 1'b1;
    wait_done(2);
    k = 0;
    while (exp_wr.size() > DEP - 3 && k < 500) begin
      @(negedge sys_clk);
      k++;
    end
    chk("round2_writing", 32'(exp_wr.size() <= DEP - 3), 32'd1);
    start = 1'b0;
    wait_done(3);
    cycles(30);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_pass_cnt", 32'(pass_cnt), 32'd3);
    chk("stop_done_pulses", 32'(done_seen), 32'd3);
    chk("stop_writes_drained", 32'(exp_wr.size()), 32'd0);

    // Randomized flag stalls and read corruption over several rounds.
    do_reset();
    rand_stall   = 1'b1;
    rand_corrupt = 1'b1;
    run_rounds(4);
    chk("random_pass_cnt", 32'(pass_cnt), 32'(tot_pass));
    chk("random_err_cnt", 32'(err_cnt), 32'(tot_err));
    chk("random_err_flag", 32'(err_flag), 32'(tot_err != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
